// File: rtl/tt_sweep_pkg.sv
// Shared types and constant helpers for the truth-table sweep controller.
// Holds the FSM state encoding and the settle-time range limits.
package tt_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } sweep_state_e;

  localparam int unsigned SETTLE_MIN = 1;
  localparam int unsigned SETTLE_MAX = 255;
  localparam int unsigned CNT_W      = 8;

  function automatic int unsigned tt_width(input int unsigned n_in);
    return 32'd1 << n_in;
  endfunction

  function automatic bit settle_legal(input int unsigned s);
    return (s >= SETTLE_MIN) && (s <= SETTLE_MAX);
  endfunction

  // An out-of-range settle time is pinned to the nearest legal value
  // so the 8-bit timer always reaches its terminal count.
  function automatic int unsigned settle_clamp(input int unsigned s);
    if (settle_legal(s)) return s;
    if (s < SETTLE_MIN) return SETTLE_MIN;
    return SETTLE_MAX;
  endfunction

endpackage

// File: rtl/tt_sweep_ctrl_settle_timer.sv
// Per-vector settle counter: counts enabled cycles, flags SETTLE_CYCLES-1.
// Cleared by the controller whenever a new vector is about to be driven.
module settle_timer
  import tt_sweep_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned       SETTLE_EFF = settle_clamp(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0]  TC_VAL     = CNT_W'(SETTLE_EFF - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Exhaustive truth-table sweeper: drives every input vector, samples f_in
// after a settle time and compares the result against a latched expected mask.
module tt_sweep_ctrl
  import tt_sweep_pkg::*;
#(
  parameter  int unsigned N_IN          = 4,
  parameter  int unsigned SETTLE_CYCLES = 2,
  localparam int unsigned TT_W          = tt_width(N_IN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [TT_W-1:0] expected,
  input  logic            f_in,
  output logic [N_IN-1:0] vec,
  output logic            busy,
  output logic            done,
  output logic [TT_W-1:0] captured,
  output logic [N_IN:0]   mismatch_cnt,
  output logic [N_IN-1:0] first_fail_idx,
  output logic            fail_valid,
  output logic            pass
);

  localparam int unsigned   IDX_W    = N_IN + 1;
  localparam logic [N_IN:0] IDX_LAST = IDX_W'(TT_W - 1);

  sweep_state_e    state_q, state_d;
  logic [TT_W-1:0] exp_q, exp_d;
  logic [N_IN:0]   idx_q, idx_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [TT_W-1:0] captured_q, captured_d;
  logic [N_IN:0]   cnt_q, cnt_d;
  logic [N_IN-1:0] ffi_q, ffi_d;
  logic            fv_q, fv_d;
  logic            pass_q, pass_d;

  logic timer_clr, timer_en, timer_tc;

  settle_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_settle_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (timer_clr),
    .en    (timer_en),
    .tc    (timer_tc)
  );

  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    idx_d      = idx_q;
    captured_d = captured_q;
    cnt_d      = cnt_q;
    ffi_d      = ffi_q;
    fv_d       = fv_q;
    pass_d     = pass_q;
    done_d     = 1'b0;
    timer_clr  = 1'b0;
    timer_en   = 1'b0;

    if (abort) begin
      // Results stay frozen for debug; only the verdict is withdrawn.
      state_d   = ST_IDLE;
      pass_d    = 1'b0;
      timer_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          timer_clr = 1'b1;
          if (start) begin
            exp_d      = expected;
            captured_d = '0;
            cnt_d      = '0;
            ffi_d      = '0;
            fv_d       = 1'b0;
            pass_d     = 1'b0;
            idx_d      = '0;
            state_d    = ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          timer_en = 1'b1;
          if (timer_tc) begin
            state_d = ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          timer_clr = 1'b1;
          captured_d[idx_q[N_IN-1:0]] = f_in;
          if (f_in != exp_q[idx_q[N_IN-1:0]]) begin
            cnt_d = cnt_q + IDX_W'(1);
            if (!fv_q) begin
              ffi_d = idx_q[N_IN-1:0];
              fv_d  = 1'b1;
            end
          end
          if (idx_q == IDX_LAST) begin
            // Verdict is taken from the count including this final sample,
            // so it lines up with the done pulse.
            state_d = ST_DONE;
            done_d  = 1'b1;
            pass_d  = (cnt_d == '0);
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_DRIVE;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d == ST_DRIVE) || (state_d == ST_SAMPLE);
    vec_d  = busy_d ? idx_d[N_IN-1:0] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      exp_q      <= '0;
      idx_q      <= '0;
      vec_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      captured_q <= '0;
      cnt_q      <= '0;
      ffi_q      <= '0;
      fv_q       <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      exp_q      <= exp_d;
      idx_q      <= idx_d;
      vec_q      <= vec_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      captured_q <= captured_d;
      cnt_q      <= cnt_d;
      ffi_q      <= ffi_d;
      fv_q       <= fv_d;
      pass_q     <= pass_d;
    end
  end

  assign vec            = vec_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign captured       = captured_q;
  assign mismatch_cnt   = cnt_q;
  assign first_fail_idx = ffi_q;
  assign fail_valid     = fv_q;
  assign pass           = pass_q;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Self-checking bench for tt_sweep_ctrl: directed and randomized sweeps
// compared against a truth-table level reference model.
module tb_tt_sweep_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Default-parameter instance
  logic        start = 1'b0, abort = 1'b0, f_in;
  logic [15:0] exp_tt = '0, flip = '0;
  logic        force1 = 1'b0;
  logic [3:0]  vec, ffi;
  logic        busy, done, fv, pass;
  logic [15:0] captured;
  logic [4:0]  mcnt;

  // SETTLE_CYCLES = 1 instance
  logic        start1 = 1'b0, f1_in;
  logic [3:0]  vec1, ffi1;
  logic        busy1, done1, fv1, pass1;
  logic [15:0] captured1;
  logic [4:0]  mcnt1;

  always_comb f_in  = force1 ? 1'b1 : (exp_tt[vec] ^ flip[vec]);
  always_comb f1_in = exp_tt[vec1];

  tt_sweep_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .expected(exp_tt),
    .f_in(f_in), .vec(vec), .busy(busy), .done(done), .captured(captured),
    .mismatch_cnt(mcnt), .first_fail_idx(ffi), .fail_valid(fv), .pass(pass)
  );

  tt_sweep_ctrl #(.N_IN(4), .SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(1'b0), .expected(exp_tt),
    .f_in(f1_in), .vec(vec1), .busy(busy1), .done(done1), .captured(captured1),
    .mismatch_cnt(mcnt1), .first_fail_idx(ffi1), .fail_valid(fv1), .pass(pass1)
  );

  // Reference: the measured table is what the function produces; results follow
  // from comparing whole tables.
  task automatic model(output logic [15:0] cap, output int cnt, output int first,
                       output logic valid, output logic ok);
    logic [15:0] diff;
    cap   = force1 ? 16'hFFFF : (exp_tt ^ flip);
    diff  = cap ^ exp_tt;
    cnt   = $countones(diff);
    valid = (cnt != 0);
    ok    = (cnt == 0);
    first = 0;
    for (int i = 15; i >= 0; i--) if (diff[i]) first = i;
  endtask

  // Pulses start, then watches 60 cycles; cycle c is the one after edge c-1.
  task automatic run_sweep(input int repulse_cyc, output int done_cyc,
                           output int pulses, output int vec_bad_cyc);
    int ev;
    done_cyc = -1; pulses = 0; vec_bad_cyc = -1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      start = (c == repulse_cyc);
      if (done === 1'b1) begin
        pulses++;
        if (done_cyc < 0) done_cyc = c;
      end
      ev = (c <= 48) ? (c - 1) / 3 : 0;
      if (vec !== 4'(ev) && vec_bad_cyc < 0) vec_bad_cyc = c;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({vec, busy, done, captured, mcnt, ffi, fv, pass} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h required=0", {vec, busy, done, captured, mcnt, ffi, fv, pass});
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_match();
    int dc, np, vb, rc, rf;
    logic [15:0] rcap; logic rv, rp;
    exp_tt = 16'hA5A5; flip = '0; force1 = 1'b0;
    model(rcap, rc, rf, rv, rp);
    run_sweep(-1, dc, np, vb);
    checks++; if (dc !== 49) begin failures++; $display("FAIL match_done_cycle got=%0d required=49", dc); end
    checks++; if (np !== 1) begin failures++; $display("FAIL match_done_pulses got=%0d required=1", np); end
    checks++; if (vb !== -1) begin failures++; $display("FAIL match_vec_step first_bad_cycle=%0d required=-1", vb); end
    checks++; if (captured !== rcap) begin failures++; $display("FAIL match_captured got=%h required=%h", captured, rcap); end
    checks++; if (mcnt !== 5'(rc) || fv !== rv || pass !== rp) begin
      failures++; $display("FAIL match_result got cnt=%0d fv=%b pass=%b required cnt=%0d fv=%b pass=%b", mcnt, fv, pass, rc, rv, rp);
    end
  endtask

  task automatic test_single_fault();
    int dc, np, vb, rc, rf;
    logic [15:0] rcap; logic rv, rp;
    exp_tt = 16'hA5A5; flip = 16'h0008; force1 = 1'b0;
    model(rcap, rc, rf, rv, rp);
    run_sweep(-1, dc, np, vb);
    checks++; if (captured !== 16'hA5AD) begin failures++; $display("FAIL fault_captured got=%h required=a5ad", captured); end
    checks++; if (mcnt !== 5'(rc) || ffi !== 4'(rf) || fv !== rv || pass !== rp) begin
      failures++; $display("FAIL fault_result got cnt=%0d ffi=%0d fv=%b pass=%b required cnt=%0d ffi=%0d fv=%b pass=%b",
                           mcnt, ffi, fv, pass, rc, rf, rv, rp);
    end
    checks++; if (dc !== 49) begin failures++; $display("FAIL fault_done_cycle got=%0d required=49", dc); end
  endtask

  task automatic test_all_wrong();
    int dc, np, vb, rc, rf;
    logic [15:0] rcap; logic rv, rp;
    exp_tt = 16'h0000; flip = '0; force1 = 1'b1;
    model(rcap, rc, rf, rv, rp);
    run_sweep(-1, dc, np, vb);
    checks++; if (captured !== 16'hFFFF) begin failures++; $display("FAIL allwrong_captured got=%h required=ffff", captured); end
    checks++; if (mcnt !== 5'd16 || ffi !== 4'd0 || pass !== 1'b0 || fv !== 1'b1) begin
      failures++; $display("FAIL allwrong_result got cnt=%0d ffi=%0d fv=%b pass=%b required cnt=16 ffi=0 fv=1 pass=0", mcnt, ffi, fv, pass);
    end
    force1 = 1'b0;
  endtask

  task automatic test_start_while_busy();
    int dc, np, vb;
    exp_tt = 16'h3C5A; flip = '0;
    run_sweep(10, dc, np, vb);
    checks++; if (dc !== 49 || np !== 1) begin
      failures++; $display("FAIL busy_restart got done_cycle=%0d pulses=%0d required 49 and 1", dc, np);
    end
    checks++; if (vb !== -1) begin failures++; $display("FAIL busy_vec_step first_bad_cycle=%0d required=-1", vb); end
  endtask

  task automatic test_abort();
    int dc, np, vb, rc, rf, k, dseen;
    logic [15:0] rcap; logic rv, rp;
    exp_tt = 16'h96E1; flip = 16'h0024; force1 = 1'b0;
    model(rcap, rc, rf, rv, rp);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    k = 0;
    while (!(vec === 4'd7 && busy === 1'b1) && k < 100) begin @(negedge clk); k++; end
    checks++; if (k >= 100) begin failures++; $display("FAIL abort_reach_idx7 timeout got=%0d required=<100", k); end
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    checks++; if (vec !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin
      failures++; $display("FAIL abort_idle got vec=%0d busy=%b done=%b pass=%b required 0 0 0 0", vec, busy, done, pass);
    end
    checks++; if (captured !== (rcap & 16'h007F)) begin
      failures++; $display("FAIL abort_captured got=%h required=%h", captured, rcap & 16'h007F);
    end
    checks++; if (mcnt !== 5'($countones((rcap ^ exp_tt) & 16'h007F)) || ffi !== 4'd2 || fv !== 1'b1) begin
      failures++; $display("FAIL abort_partial got cnt=%0d ffi=%0d fv=%b required cnt=%0d ffi=2 fv=1",
                           mcnt, ffi, fv, $countones((rcap ^ exp_tt) & 16'h007F));
    end
    dseen = 0;
    for (int i = 0; i < 20; i++) begin if (done === 1'b1 || busy === 1'b1) dseen++; @(negedge clk); end
    checks++; if (dseen !== 0) begin failures++; $display("FAIL abort_stays_idle got=%0d required=0", dseen); end
    run_sweep(-1, dc, np, vb);
    checks++; if (dc !== 49 || captured !== rcap || mcnt !== 5'(rc) || pass !== rp) begin
      failures++; $display("FAIL abort_restart got done=%0d cap=%h cnt=%0d pass=%b required 49 %h %0d %b", dc, captured, mcnt, pass, rcap, rc, rp);
    end
    flip = '0;
  endtask

  task automatic test_abort_start_idle();
    int k;
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    k = 0;
    for (int i = 0; i < 5; i++) begin if (busy === 1'b1) k++; @(negedge clk); end
    checks++; if (k !== 0) begin failures++; $display("FAIL abort_start_idle busy_cycles=%0d required=0", k); end
  endtask

  task automatic test_async_reset();
    int k;
    exp_tt = 16'hA5A5; flip = 16'h0002;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    k = 0;
    while (vec !== 4'd5 && k < 100) begin @(negedge clk); k++; end
    checks++; if (k >= 100) begin failures++; $display("FAIL reset_reach_idx5 timeout got=%0d required=<100", k); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({vec, busy, done, captured, mcnt, ffi, fv, pass} !== '0) begin
      failures++; $display("FAIL async_reset got=%h required=0", {vec, busy, done, captured, mcnt, ffi, fv, pass});
    end
    @(negedge clk); rst_n = 1'b1; flip = '0;
    k = 0;
    for (int i = 0; i < 10; i++) begin if (done === 1'b1 || busy === 1'b1) k++; @(negedge clk); end
    checks++; if (k !== 0) begin failures++; $display("FAIL reset_no_done got=%0d required=0", k); end
  endtask

  task automatic test_settle1();
    int dc, np;
    exp_tt = 16'h5A0F;
    dc = -1; np = 0;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      if (done1 === 1'b1) begin np++; if (dc < 0) dc = c; end
      @(negedge clk);
    end
    checks++; if (dc !== 33 || np !== 1) begin
      failures++; $display("FAIL settle1_done got cycle=%0d pulses=%0d required 33 and 1", dc, np);
    end
    checks++; if (pass1 !== 1'b1 || captured1 !== exp_tt || mcnt1 !== 5'd0) begin
      failures++; $display("FAIL settle1_result got pass=%b cap=%h cnt=%0d required 1 %h 0", pass1, captured1, mcnt1, exp_tt);
    end
  endtask

  task automatic test_random();
    int dc, np, vb, rc, rf;
    logic [15:0] rcap; logic rv, rp;
    for (int n = 0; n < 6; n++) begin
      exp_tt = 16'($urandom);
      flip   = (n == 0) ? 16'h0000 : 16'($urandom & $urandom & $urandom);
      force1 = ($urandom_range(0, 7) == 0);
      model(rcap, rc, rf, rv, rp);
      run_sweep(-1, dc, np, vb);
      checks++;
      if (dc !== 49 || np !== 1 || captured !== rcap || mcnt !== 5'(rc) || ffi !== 4'(rf) || fv !== rv || pass !== rp) begin
        failures++;
        $display("FAIL random_%0d got done=%0d pulses=%0d cap=%h cnt=%0d ffi=%0d fv=%b pass=%b required 49 1 %h %0d %0d %b %b",
                 n, dc, np, captured, mcnt, ffi, fv, pass, rcap, rc, rf, rv, rp);
      end
    end
    force1 = 1'b0; flip = '0;
  endtask

  initial begin
    test_reset();
    test_match();
    test_single_fault();
    test_all_wrong();
    test_start_while_busy();
    test_abort();
    test_abort_start_idle();
    test_async_reset();
    test_settle1();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
